// File: rtl/crypto_keyslot_wrapper_if.sv
// Register-bus interface for crypto_keyslot_wrapper.
// Carries one word-addressed register access per cycle.
// Signals:
//   en_i    - access strobe
//   we_i    - write enable (1 = write, 0 = read)
//   addr_i  - word index
//   wdata_i - write data
//   rdata_o - combinational read data
// Modports:
//   master - the AXI-lite bridge side
//   slave  - the wrapper side
interface crypto_keyslot_wrapper_if;
  logic        en_i;
  logic        we_i;
  logic [5:0]  addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;

  modport master (output en_i, output we_i, output addr_i, output wdata_i, input rdata_o);
  modport slave  (input en_i, input we_i, input addr_i, input wdata_i, output rdata_o);
endinterface

// File: rtl/crypto_keyslot_wrapper.sv
// Multi-slot key register front-end and start/busy/done sequencer for a block-cipher core.
// Optional feature: define CRYPTO_KEYSLOT_TEXT_SCRUB_EN to zero TEXT/STATE when an
// operation completes (result captured) or times out (ERR entered).
// Ports:
//   clk_i, rst_i   - clock, synchronous active-high reset
//   reglk_ctrl_i   - lock bits: [0] CTRL wr, [1] TEXT/STATE wr, [2] TEXT rd,
//                    [3] KEY wr, [4] RESULT rd, [5] KEY_SEL wr
//   acct_ctrl_i    - access permission
//   debug_mode_i   - zeroises the key path while high
//   reg_bus        - register access bus (en/we/addr/wdata, combinational rdata)
//   core_start_o   - one-cycle start pulse to the core
//   core_key_o     - selected key
//   core_text_o    - text input to the core
//   core_state_o   - state input to the core
//   core_out_i     - core result
//   core_valid_i   - core result valid
module crypto_keyslot_wrapper #(
  parameter int unsigned NUM_KEYS   = 3,
  parameter int unsigned KEY_WORDS  = 6,
  parameter int unsigned TEXT_WORDS = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [7:0]                reglk_ctrl_i,
  input  logic                      acct_ctrl_i,
  input  logic                      debug_mode_i,
  crypto_keyslot_wrapper_if.slave   reg_bus,
  output logic                      core_start_o,
  output logic [32*KEY_WORDS-1:0]   core_key_o,
  output logic [32*TEXT_WORDS-1:0]  core_text_o,
  output logic [32*TEXT_WORDS-1:0]  core_state_o,
  input  logic [32*TEXT_WORDS-1:0]  core_out_i,
  input  logic                      core_valid_i
);

  localparam int unsigned KSW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int unsigned CW  = 16;
  localparam int unsigned KWB = 32 * KEY_WORDS;
  localparam int unsigned TWB = 32 * TEXT_WORDS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_BUSY,
    ST_DONE,
    ST_ERR
  } fsm_e;

  fsm_e                          fsm_q, fsm_d;
  logic [CW-1:0]                 cnt_q;
  logic [KSW-1:0]                key_sel_q;
  logic [NUM_KEYS-1:0][KWB-1:0]  key_q;
  logic [TWB-1:0]                text_q;
  logic [TWB-1:0]                state_q;
  logic [TWB-1:0]                result_q;
  logic                          debug_q;
  logic                          start_q;

  logic        cnt_clr, cnt_inc, res_clr, res_cap, scrub;
  logic        acc, wr, rd;
  logic        busy, done, err, cfg_open;
  logic [5:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ctrl_wr, start_req, clear_req;
  logic        ksel_wr, text_wr, state_wr, key_wr;
  logic        text_hit, state_hit, key_hit;
  logic [2:0]  key_idx;
  logic        dbg_rise;
  logic        unused_ok;

  // Access decode
  assign addr  = reg_bus.addr_i;
  assign wdata = reg_bus.wdata_i;
  assign acc   = reg_bus.en_i & acct_ctrl_i;
  assign wr    = acc & reg_bus.we_i;
  assign rd    = acc & ~reg_bus.we_i;

  assign busy     = (fsm_q == ST_LOAD) || (fsm_q == ST_BUSY);
  assign done     = (fsm_q == ST_DONE);
  assign err      = (fsm_q == ST_ERR);
  // Operands are frozen while the core is running
  assign cfg_open = ~busy;

  assign ctrl_wr   = wr && (addr == 6'd0) && !reglk_ctrl_i[0];
  assign clear_req = ctrl_wr & wdata[1];
  assign start_req = ctrl_wr & wdata[0] & ~wdata[1];

  assign ksel_wr = wr && (addr == 6'd2) && !reglk_ctrl_i[5] && cfg_open && (wdata < NUM_KEYS);

  assign text_hit  = (addr[5:2] == 4'd1) && (32'(addr[1:0]) < TEXT_WORDS);
  assign state_hit = (addr[5:2] == 4'd2) && (32'(addr[1:0]) < TEXT_WORDS);
  assign text_wr   = wr && text_hit  && !reglk_ctrl_i[1] && cfg_open;
  assign state_wr  = wr && state_hit && !reglk_ctrl_i[1] && cfg_open;

  // Key words live at 16 + 8*k + w; addr[5:3] - 2 yields the slot number
  assign key_idx = addr[5:3] - 3'd2;
  assign key_hit = (addr[5:4] != 2'b00) && (32'(key_idx) < NUM_KEYS) &&
                   (32'(addr[2:0]) < KEY_WORDS);
  assign key_wr  = wr && key_hit && !reglk_ctrl_i[3] && cfg_open && !debug_mode_i;

  assign dbg_rise = debug_mode_i & ~debug_q;

  assign unused_ok = ^{reglk_ctrl_i[7:6], scrub};

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q <= ST_IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // FSM next state and datapath controls
  always_comb begin
    fsm_d   = fsm_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    res_clr = 1'b0;
    res_cap = 1'b0;
    scrub   = 1'b0;
    case (fsm_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_req && !debug_mode_i) begin
          fsm_d   = ST_LOAD;
          res_clr = 1'b1;
          cnt_clr = 1'b1;
        end
      end
      ST_LOAD: begin
        fsm_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (core_valid_i) begin
          fsm_d   = ST_DONE;
          res_cap = 1'b1;
          scrub   = 1'b1;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          fsm_d = ST_ERR;
          scrub = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
    // Clear overrides everything, including a same-cycle result
    if (clear_req) begin
      fsm_d   = ST_IDLE;
      res_clr = 1'b1;
      res_cap = 1'b0;
      scrub   = 1'b0;
      cnt_clr = 1'b1;
      cnt_inc = 1'b0;
    end
  end

  // Register file, counter and result capture
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      key_sel_q <= '0;
      key_q     <= '0;
      text_q    <= '0;
      state_q   <= '0;
      result_q  <= '0;
      debug_q   <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      debug_q <= debug_mode_i;
      start_q <= (fsm_d == ST_LOAD);

      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + CW'(1);
      end

      if (ksel_wr) begin
        key_sel_q <= KSW'(wdata);
      end

      for (int i = 0; i < TEXT_WORDS; i++) begin
        if (text_wr && (addr[1:0] == 2'(i))) begin
          text_q[32*i +: 32] <= wdata;
        end
        if (state_wr && (addr[1:0] == 2'(i))) begin
          state_q[32*i +: 32] <= wdata;
        end
      end
`ifdef CRYPTO_KEYSLOT_TEXT_SCRUB_EN
      // Plaintext is dropped once the core no longer needs it
      if (scrub) begin
        text_q  <= '0;
        state_q <= '0;
      end
`endif

      // Entering debug zeroises every slot; it also beats a same-cycle key write
      if (dbg_rise) begin
        key_q <= '0;
      end else begin
        for (int k = 0; k < NUM_KEYS; k++) begin
          for (int w = 0; w < KEY_WORDS; w++) begin
            if (key_wr && (key_idx == 3'(k)) && (addr[2:0] == 3'(w))) begin
              key_q[k][32*w +: 32] <= wdata;
            end
          end
        end
      end

      if (res_clr) begin
        result_q <= '0;
      end else if (res_cap) begin
        result_q <= core_out_i;
      end
    end
  end

  // Read mux; key words are never readable
  always_comb begin
    rdata = '0;
    if (rd) begin
      if (addr == 6'd1) begin
        rdata = {29'd0, err, done, busy};
      end
      if (addr == 6'd2) begin
        rdata = 32'(key_sel_q);
      end
      for (int i = 0; i < TEXT_WORDS; i++) begin
        if ((addr == 6'(4 + i)) && !reglk_ctrl_i[2]) begin
          rdata = text_q[32*i +: 32];
        end
        if ((addr == 6'(12 + i)) && !reglk_ctrl_i[4] && done) begin
          rdata = result_q[32*i +: 32];
        end
      end
    end
  end

  assign reg_bus.rdata_o = rdata;

  // Selected key, forced to zero in debug mode without waiting for a clock
  always_comb begin
    core_key_o = '0;
    if (!debug_mode_i) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (key_sel_q == KSW'(k)) begin
          core_key_o = key_q[k];
        end
      end
    end
  end

  assign core_start_o = start_q;
  assign core_text_o  = text_q;
  assign core_state_o = state_q;

endmodule

// File: tb/tb_crypto_keyslot_wrapper.sv
// Self-checking bench for crypto_keyslot_wrapper with a transaction-level model.
module tb_crypto_keyslot_wrapper;

  localparam int NK = 3;
  localparam int KW = 6;
  localparam int TW = 4;
  localparam int TO = 64;
  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_DONE = 2;
  localparam int P_ERR  = 3;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [7:0]        reglk;
  logic              acct;
  logic              dbg;
  logic              core_start;
  logic [32*KW-1:0]  core_key;
  logic [32*TW-1:0]  core_text;
  logic [32*TW-1:0]  core_state;
  logic [32*TW-1:0]  core_out;
  logic              core_valid;

  always #50 clk_i = ~clk_i;

  crypto_keyslot_wrapper_if bus_if ();

  crypto_keyslot_wrapper #(
    .NUM_KEYS(NK), .KEY_WORDS(KW), .TEXT_WORDS(TW), .TIMEOUT(TO)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .reglk_ctrl_i (reglk),
    .acct_ctrl_i  (acct),
    .debug_mode_i (dbg),
    .reg_bus      (bus_if),
    .core_start_o (core_start),
    .core_key_o   (core_key),
    .core_text_o  (core_text),
    .core_state_o (core_state),
    .core_out_i   (core_out),
    .core_valid_i (core_valid)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: architectural register contents and operation phase
  logic [31:0] m_key   [NK][KW];
  logic [31:0] m_text  [TW];
  logic [31:0] m_state [TW];
  logic [31:0] m_res   [TW];
  int          m_sel;
  int          m_phase;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic mdl_reset();
    for (int k = 0; k < NK; k++) for (int w = 0; w < KW; w++) m_key[k][w] = '0;
    for (int i = 0; i < TW; i++) begin
      m_text[i] = '0; m_state[i] = '0; m_res[i] = '0;
    end
    m_sel   = 0;
    m_phase = P_IDLE;
  endtask

  task automatic mdl_scrub();
`ifdef CRYPTO_KEYSLOT_TEXT_SCRUB_EN
    for (int i = 0; i < TW; i++) begin
      m_text[i] = '0; m_state[i] = '0;
    end
`endif
  endtask

  // Effect of one register write under the access/lock/phase rules
  task automatic mdl_write(input logic [5:0] a, input logic [31:0] d);
    int ia;
    ia = int'(a);
    if (!acct) return;
    if (ia == 0) begin
      if (!reglk[0]) begin
        if (d[1]) begin
          m_phase = P_IDLE;
          for (int i = 0; i < TW; i++) m_res[i] = '0;
        end else if (d[0] && m_phase != P_RUN && !dbg) begin
          m_phase = P_RUN;
          for (int i = 0; i < TW; i++) m_res[i] = '0;
        end
      end
    end else if (ia == 2) begin
      if (!reglk[5] && m_phase != P_RUN && d < NK) m_sel = int'(d);
    end else if (ia >= 4 && ia < 4 + TW) begin
      if (!reglk[1] && m_phase != P_RUN) m_text[ia-4] = d;
    end else if (ia >= 8 && ia < 8 + TW) begin
      if (!reglk[1] && m_phase != P_RUN) m_state[ia-8] = d;
    end else if (ia >= 16 && ia < 16 + 8*NK && ((ia - 16) % 8) < KW) begin
      if (!reglk[3] && m_phase != P_RUN && !dbg) m_key[(ia-16)/8][(ia-16)%8] = d;
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    mdl_write(a, d);
    @(negedge clk_i);
    bus_if.en_i = 1'b1; bus_if.we_i = 1'b1; bus_if.addr_i = a; bus_if.wdata_i = d;
    @(posedge clk_i);
    #1;
    bus_if.en_i = 1'b0; bus_if.we_i = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] v);
    bus_if.en_i = 1'b1; bus_if.we_i = 1'b0; bus_if.addr_i = a;
    #1;
    v = bus_if.rdata_o;
    bus_if.en_i = 1'b0;
  endtask

  function automatic logic [31:0] status_exp();
    case (m_phase)
      P_RUN:   return 32'h1;
      P_DONE:  return 32'h2;
      P_ERR:   return 32'h4;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [255:0] exp_key();
    logic [255:0] r;
    r = '0;
    if (!dbg) for (int w = 0; w < KW; w++) r[32*w +: 32] = m_key[m_sel][w];
    return r;
  endfunction

  function automatic logic [255:0] exp_text();
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < TW; i++) r[32*i +: 32] = m_text[i];
    return r;
  endfunction

  function automatic logic [255:0] exp_state();
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < TW; i++) r[32*i +: 32] = m_state[i];
    return r;
  endfunction

  // Full observable-state comparison against the model
  task automatic check_all(input string tag);
    logic [31:0] v;
    rd(6'd1, v);  chk({tag, ".status"}, 256'(v), acct ? 256'(status_exp()) : '0);
    rd(6'd2, v);  chk({tag, ".keysel"}, 256'(v), acct ? 256'(m_sel) : '0);
    for (int i = 0; i < TW; i++) begin
      rd(6'(4 + i), v);
      chk({tag, ".text"}, 256'(v), (acct && !reglk[2]) ? 256'(m_text[i]) : '0);
      rd(6'(12 + i), v);
      chk({tag, ".result"}, 256'(v),
          (acct && !reglk[4] && m_phase == P_DONE) ? 256'(m_res[i]) : '0);
    end
    rd(6'd16, v); chk({tag, ".keyrd"}, 256'(v), '0);
    chk({tag, ".core_key"},   256'(core_key),   exp_key());
    chk({tag, ".core_text"},  256'(core_text),  exp_text());
    chk({tag, ".core_state"}, 256'(core_state), exp_state());
  endtask

  // Start an operation and return a result after lat BUSY cycles
  task automatic run_op(input int lat, input logic [32*TW-1:0] out);
    logic [31:0] v;
    wr(6'd0, 32'h1);
    chk("start_pulse", 256'(core_start), 256'(1));
    rd(6'd1, v); chk("load_status", 256'(v), 256'(1));
    tick();
    chk("start_drop", 256'(core_start), 256'(0));
    repeat (lat - 1) tick();
    rd(6'd1, v); chk("busy_status", 256'(v), 256'(1));
    @(negedge clk_i);
    core_valid = 1'b1; core_out = out;
    @(posedge clk_i);
    #1;
    core_valid = 1'b0;
    m_phase = P_DONE;
    for (int i = 0; i < TW; i++) m_res[i] = out[32*i +: 32];
    mdl_scrub();
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int n;

    rst_i = 1'b1; reglk = '0; acct = 1'b1; dbg = 1'b0;
    core_valid = 1'b0; core_out = '0;
    bus_if.en_i = 1'b0; bus_if.we_i = 1'b0; bus_if.addr_i = '0; bus_if.wdata_i = '0;
    mdl_reset();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i) rst_i = 1'b0;
    tick();
    check_all("reset");
    chk("reset.start", 256'(core_start), '0);

    // Load all slots, select slot 1, run with the documented text and result
    for (int k = 0; k < NK; k++)
      for (int w = 0; w < KW; w++) wr(6'(16 + 8*k + w), $urandom);
    wr(6'd2, 32'd1);
    for (int i = 0; i < TW; i++) wr(6'(4 + i), 32'h11111111 * 32'(i + 1));
    for (int i = 0; i < TW; i++) wr(6'(8 + i), $urandom);
    check_all("loaded");
    run_op(10, {TW{32'hA5A5A5A5}});
    check_all("done");
    tick(); tick();
    check_all("done_hold");

    // Out-of-range KEY_SEL and clear+start in one write
    wr(6'd2, 32'd3);
    wr(6'd0, 32'h3);
    chk("clr_start.pulse", 256'(core_start), '0);
    check_all("clr_start");

    // Timeout: count BUSY cycles until ERR
    wr(6'd0, 32'h1);
    n = 0;
    v = '0;
    for (int c = 0; c < 200; c++) begin
      tick();
      rd(6'd1, v);
      if (v == 32'h1) n++;
      else break;
    end
    chk("timeout.cycles", 256'(n), 256'(TO));
    chk("timeout.status", 256'(v), 256'(4));
    m_phase = P_ERR;
    mdl_scrub();
    check_all("err");

    // Locks and access permission
    run_op($urandom_range(1, 12), {$urandom, $urandom, $urandom, $urandom});
    reglk = 8'h1C;
    wr(6'(16 + 8*m_sel), $urandom);
    check_all("lock1c");
    reglk = 8'h01;
    wr(6'd0, 32'h1);
    check_all("lock_ctrl");
    reglk = 8'h00;
    check_all("unlock");
    acct = 1'b0;
    wr(6'd2, 32'd0);
    check_all("noacct");
    acct = 1'b1;

    // Writes during BUSY are ignored; clear beats a same-cycle valid
    wr(6'd0, 32'h1);
    tick();
    wr(6'd0, 32'h1);
    wr(6'd2, 32'd0);
    wr(6'd4, $urandom);
    check_all("busy_ignore");
    mdl_write(6'd0, 32'h2);
    @(negedge clk_i);
    bus_if.en_i = 1'b1; bus_if.we_i = 1'b1; bus_if.addr_i = 6'd0; bus_if.wdata_i = 32'h2;
    core_valid = 1'b1; core_out = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk_i);
    #1;
    bus_if.en_i = 1'b0; bus_if.we_i = 1'b0; core_valid = 1'b0;
    check_all("clear_vs_valid");

    // Debug mode: immediate key masking, zeroisation, start blocked
    @(negedge clk_i);
    dbg = 1'b1;
    #1;
    chk("dbg.key_now", 256'(core_key), '0);
    tick();
    for (int k = 0; k < NK; k++) for (int w = 0; w < KW; w++) m_key[k][w] = '0;
    wr(6'd0, 32'h1);
    wr(6'd16, $urandom);
    tick();
    check_all("dbg_on");
    @(negedge clk_i);
    dbg = 1'b0;
    #1;
    for (int k = 0; k < NK; k++) begin
      wr(6'd2, 32'(k));
      check_all("dbg_off");
    end

    // Fresh key and random operation after debug
    for (int w = 0; w < KW; w++) wr(6'(16 + 8*2 + w), $urandom);
    for (int i = 0; i < TW; i++) wr(6'(4 + i), $urandom);
    run_op($urandom_range(1, TO), {$urandom, $urandom, $urandom, $urandom});
    check_all("rand_op");

    // Reset mid-operation; a late valid is ignored
    wr(6'd0, 32'h1);
    tick();
    @(negedge clk_i) rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    rst_i = 1'b0;
    core_valid = 1'b1; core_out = {TW{32'hDEADBEEF}};
    @(posedge clk_i);
    #1;
    core_valid = 1'b0;
    mdl_reset();
    check_all("reset_mid");
    chk("reset_mid.start", 256'(core_start), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
